// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared types and constants for the RV32I fetch front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    // Fetch controller state encoding
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } fetch_state_e;

    // Size of one RV32I instruction in bytes (PC increment)
    localparam int unsigned INST_BYTES = 4;

    // Canonical RV32I no-op (addi x0, x0, 0)
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_reg
//  Description : 32-bit program counter register with load enable and
//                asynchronous active-low reset to the reset vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [31:0] pc_d,
    output logic [31:0] pc_q
);

    // PC holds its value unless the fetch controller requests a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else if (load_en) begin
            pc_q <= pc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer_rv32i.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_rv32i
//  Description : RV32I fetch controller. Owns the PC, issues imem requests
//                over a req/ready handshake, holds each fetched word until
//                decode acknowledges it, applies execute redirects and traps
//                on a misaligned redirect target.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer_rv32i
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    input  logic               inst_ack,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               misalign_trap,
    output logic [COUNT_W-1:0] fetch_count
);

    fetch_state_e        state_q, state_d;
    logic                pending_q, pending_d;
    logic [31:0]         pending_pc_q, pending_pc_d;
    logic [31:0]         inst_q, inst_d;
    logic [31:0]         inst_pc_q, inst_pc_d;
    logic                trap_q, trap_d;
    logic [COUNT_W-1:0]  count_q, count_d;

    logic                pc_load;
    logic [31:0]         pc_next;
    logic [31:0]         pc_q;
    logic                misaligned;

    assign misaligned = (redirect_pc[1:0] != 2'b00);

    fetch_pc_reg #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (reset),
        .load_en (pc_load),
        .pc_d    (pc_next),
        .pc_q    (pc_q)
    );

    // Control state, pending redirect, held instruction and retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pending_q    <= 1'b0;
            pending_pc_q <= 32'h0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            trap_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            trap_q       <= trap_d;
            count_q      <= count_d;
        end
    end

    // Next-state logic; a redirect outranks both imem_ready and inst_ack
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        trap_d       = trap_q;
        count_d      = count_q;
        pc_load      = 1'b0;
        pc_next      = pc_q;

        if ((state_q != TRAP) && redirect_valid && misaligned) begin
            // A bad target kills whatever is held or in flight
            state_d   = TRAP;
            trap_d    = 1'b1;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = FETCH;
                    if (redirect_valid) begin
                        pc_load = 1'b1;
                        pc_next = redirect_pc;
                    end
                end

                FETCH: begin
                    if (redirect_valid) begin
                        if (imem_ready) begin
                            // Response for the old PC is discarded
                            pc_load   = 1'b1;
                            pc_next   = redirect_pc;
                            pending_d = 1'b0;
                        end else begin
                            // Address must stay stable until the handshake;
                            // remember the target, last redirect wins
                            pending_d    = 1'b1;
                            pending_pc_d = redirect_pc;
                        end
                    end else if (imem_ready) begin
                        if (pending_q) begin
                            pc_load   = 1'b1;
                            pc_next   = pending_pc_q;
                            pending_d = 1'b0;
                        end else begin
                            inst_d    = imem_rdata;
                            inst_pc_d = pc_q;
                            state_d   = HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        pc_load = 1'b1;
                        pc_next = redirect_pc;
                        state_d = FETCH;
                    end else if (inst_ack) begin
                        pc_load = 1'b1;
                        pc_next = pc_q + 32'(INST_BYTES);
                        count_d = count_q + COUNT_W'(1);
                        state_d = FETCH;
                    end
                end

                default: begin
                    // TRAP: only reset leaves this state
                    state_d = TRAP;
                end
            endcase
        end
    end

    assign imem_req      = (state_q == FETCH);
    assign imem_addr     = pc_q;
    assign inst_valid    = (state_q == HOLD);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign misalign_trap = trap_q;
    assign fetch_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer_rv32i.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer_rv32i
//  Description : Self-checking bench for fetch_sequencer_rv32i. A reference
//                model predicts outputs after each clock; a monitor compares
//                them against the DUT from a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer_rv32i;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_trap;
    logic [31:0] fetch_count;

    fetch_sequencer_rv32i #(
        .RESET_VECTOR (RV),
        .COUNT_W      (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ack       (inst_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_trap  (misalign_trap),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] word;
        logic [31:0] wpc;
        logic        trap;
        logic [31:0] count;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: what the fetch unit has "in hand" after each clock
    logic [31:0] m_next_addr;   // address the next fetch will use
    logic        m_booting;     // still inside the idle cycle after reset
    logic        m_trapped;
    logic        m_have_word;   // an instruction is waiting for decode
    logic [31:0] m_word;
    logic [31:0] m_word_pc;
    logic        m_have_target; // redirect waiting for the fetch to finish
    logic [31:0] m_target;
    logic [31:0] m_retired;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_init();
        m_next_addr   = RV;
        m_booting     = 1'b1;
        m_trapped     = 1'b0;
        m_have_word   = 1'b0;
        m_word        = 32'h0;
        m_word_pc     = 32'h0;
        m_have_target = 1'b0;
        m_target      = 32'h0;
        m_retired     = 32'h0;
    endtask

    // Advance the model by one clock given this cycle's inputs
    task automatic model_step(input logic rdy, input logic [31:0] rdata, input logic ack,
                              input logic rv, input logic [31:0] rpc);
        if (m_trapped) begin
            // nothing moves
        end else if (rv && (rpc % 4 != 0)) begin
            m_trapped     = 1'b1;
            m_have_word   = 1'b0;
            m_have_target = 1'b0;
        end else if (m_booting) begin
            m_booting = 1'b0;
            if (rv) m_next_addr = rpc;
        end else if (m_have_word) begin
            if (rv) begin
                m_have_word = 1'b0;
                m_next_addr = rpc;
            end else if (ack) begin
                m_have_word = 1'b0;
                m_next_addr = m_next_addr + 4;
                m_retired   = m_retired + 1;
            end
        end else begin
            if (rv && rdy) begin
                m_next_addr   = rpc;
                m_have_target = 1'b0;
            end else if (rv) begin
                m_have_target = 1'b1;
                m_target      = rpc;
            end else if (rdy && m_have_target) begin
                m_next_addr   = m_target;
                m_have_target = 1'b0;
            end else if (rdy) begin
                m_have_word = 1'b1;
                m_word      = rdata;
                m_word_pc   = m_next_addr;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.req   = !m_trapped && !m_booting && !m_have_word;
        e.addr  = m_next_addr;
        e.valid = m_have_word;
        e.word  = m_word;
        e.wpc   = m_word_pc;
        e.trap  = m_trapped;
        e.count = m_retired;
        return e;
    endfunction

    // Drive one cycle of stimulus (called at a negedge), predict, wait
    task automatic step(input logic rdy, input logic ack, input logic rv, input logic [31:0] rpc);
        logic [31:0] rdata;
        rdata          = $urandom;
        imem_ready     = rdy;
        imem_rdata     = rdata;
        inst_ack       = ack;
        redirect_valid = rv;
        redirect_pc    = rpc;
        model_step(rdy, rdata, ack, rv, rpc);
        q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"},   {31'h0, imem_req}, 32'h0);
        chk({tag, "_addr"},  imem_addr, RV);
        chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
        chk({tag, "_trap"},  {31'h0, misalign_trap}, 32'h0);
        chk({tag, "_count"}, fetch_count, 32'h0);
        chk({tag, "_inst"},  inst, 32'h0);
        chk({tag, "_ipc"},   inst_pc, 32'h0);
    endtask

    // Asynchronous reset pulse lasting one cycle
    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        model_init();
    endtask

    // Monitor: compare DUT outputs with the oldest prediction after each edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset && q.size() > 0) begin
            e = q.pop_front();
            chk("imem_req", {31'h0, imem_req}, {31'h0, e.req});
            if (e.req) chk("imem_addr", imem_addr, e.addr);
            chk("inst_valid", {31'h0, inst_valid}, {31'h0, e.valid});
            if (e.valid) begin
                chk("inst", inst, e.word);
                chk("inst_pc", inst_pc, e.wpc);
            end
            chk("misalign_trap", {31'h0, misalign_trap}, {31'h0, e.trap});
            chk("fetch_count", fetch_count, e.count);
        end
    end

    initial begin
        int trap_cycles;
        reset          = 1'b0;
        imem_ready     = 1'b0;
        imem_rdata     = 32'h0;
        inst_ack       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_init();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;

        // Streaming fetch with memory and decode always ready
        repeat (8) step(1, 1, 0, 0);

        // Stalled memory then decode back-pressure
        repeat (3) step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 0, 0);

        // Redirect while holding, with ack also high
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h0000_C000);
        repeat (4) step(1, 1, 0, 0);

        // Redirect while stalled, then a second one overwriting it
        step(0, 0, 1, 32'h0000_2000);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 1, 32'h0000_3000);
        step(0, 0, 1, 32'h0000_4000);
        step(1, 1, 0, 0);
        repeat (3) step(1, 1, 0, 0);

        // PC wrap from the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFC);
        repeat (5) step(1, 1, 0, 0);

        // Misaligned target traps; only reset recovers
        step(1, 1, 1, 32'h0000_1002);
        repeat (3) step(1, 1, 0, 0);
        reset_pulse();
        repeat (6) step(1, 1, 0, 0);

        // Redirect during the boot cycle
        reset_pulse();
        step(1, 1, 1, 32'h0000_0800);
        repeat (4) step(1, 1, 0, 0);

        // Randomized traffic
        trap_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            logic        rv;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 7) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rv, rpc);
            trap_cycles = m_trapped ? trap_cycles + 1 : 0;
            if (trap_cycles > 4) begin
                reset_pulse();
                trap_cycles = 0;
            end
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
